// File: rtl/oci_trace_pkg.sv
// Shared OCI trace definitions: DCT word geometry, count/word types and the
// 2-bit trace code values produced by the CPU trace compressor.
// No ports; imported by the DCT packer and its output register users.
package oci_trace_pkg;

  localparam int DCT_CODE_W = 2;
  localparam int DCT_SLOTS  = 15;
  localparam int DCT_WORD_W = DCT_CODE_W * DCT_SLOTS;
  localparam int DCT_CNT_W  = 4;

  typedef logic [DCT_WORD_W-1:0] dct_word_t;
  typedef logic [DCT_CNT_W-1:0]  dct_cnt_t;

  typedef enum logic [1:0] {
    NOP       = 2'b00,
    TAKEN     = 2'b01,
    NOT_TAKEN = 2'b10,
    ESCAPE    = 2'b11
  } trace_code_e;

endpackage

// File: rtl/dct_out_reg.sv
// Single-entry valid/ready output register; a held word never changes while stalled.
// Ports: load/in_data capture a word (caller asserts load only when out_free),
//        out_valid/out_ready/out_data form the downstream handshake, out_free = slot usable.
module dct_out_reg #(
  parameter int DATA_W = 34
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_free
);

  // The slot can take a new word if it is empty or its word leaves this cycle.
  assign out_free = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/de2_115_web_qsys_cpu_oci_dct_packer.sv
// Packs 2-bit trace codes into 30-bit DCT words (newest code in [1:0]) with a valid-code count.
// Ports: code_in/code_valid/code_ready in, flush closes a partial word, dct_buffer/dct_count/
//        dct_valid/dct_ready out, idle when empty, words_emitted counts handshaken words.
module de2_115_web_qsys_cpu_oci_dct_packer
  import oci_trace_pkg::*;
#(
  parameter int CODE_W = DCT_CODE_W,
  parameter int SLOTS  = DCT_SLOTS,
  parameter int WCNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [CODE_W-1:0]       code_in,
  input  logic                    code_valid,
  output logic                    code_ready,
  input  logic                    flush,
  output logic [CODE_W*SLOTS-1:0] dct_buffer,
  output dct_cnt_t                dct_count,
  output logic                    dct_valid,
  input  logic                    dct_ready,
  output logic                    idle,
  output logic [WCNT_W-1:0]       words_emitted
);

  localparam int WORD_W = CODE_W * SLOTS;

  logic [WORD_W-1:0]           acc;
  dct_cnt_t                    acc_cnt;
  logic                        flush_pending;
  logic                        out_free;
  logic                        full;
  logic                        accept;
  logic                        load;
  logic [DCT_CNT_W+WORD_W-1:0] out_data;

  assign full       = (acc_cnt == DCT_CNT_W'(SLOTS));
  // A full accumulator can still take a code when its word moves out this cycle.
  assign code_ready = ~full | out_free;
  assign accept     = code_valid & code_ready;
  assign load       = out_free & (full | (flush_pending & (acc_cnt != '0)));
  assign idle       = (acc_cnt == '0) & ~dct_valid & ~flush_pending;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc     <= '0;
      acc_cnt <= '0;
    end else if (load) begin
      // Restart the accumulator; a code accepted alongside the load opens the next word.
      acc     <= accept ? WORD_W'(code_in) : '0;
      acc_cnt <= accept ? DCT_CNT_W'(1) : '0;
    end else if (accept) begin
      acc     <= {acc[WORD_W-CODE_W-1:0], code_in};
      acc_cnt <= acc_cnt + DCT_CNT_W'(1);
    end
  end

  // A load always satisfies a flush, including one arriving on the same cycle.
  // A flush that finds nothing to emit retires once the accumulator is seen empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_pending <= 1'b0;
    end else if (load) begin
      flush_pending <= 1'b0;
    end else if (flush) begin
      flush_pending <= 1'b1;
    end else if (flush_pending && acc_cnt == '0 && !accept) begin
      flush_pending <= 1'b0;
    end
  end

  dct_out_reg #(
    .DATA_W(DCT_CNT_W + WORD_W)
  ) u_out_reg (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .in_data   ({acc_cnt, acc}),
    .out_ready (dct_ready),
    .out_valid (dct_valid),
    .out_data  (out_data),
    .out_free  (out_free)
  );

  assign dct_count  = out_data[DCT_CNT_W+WORD_W-1:WORD_W];
  assign dct_buffer = out_data[WORD_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      words_emitted <= '0;
    end else if (dct_valid && dct_ready) begin
      words_emitted <= words_emitted + WCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_de2_115_web_qsys_cpu_oci_dct_packer.sv
module tb_de2_115_web_qsys_cpu_oci_dct_packer;
  import oci_trace_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  code_in = 2'b00;
  logic        code_valid = 1'b0;
  logic        code_ready;
  logic        flush = 1'b0;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid;
  logic        dct_ready = 1'b0;
  logic        idle;
  logic [15:0] words_emitted;

  int n_checks = 0;
  int n_pass = 0;
  int exp_we = 0;

  typedef struct {
    int          n;
    logic [1:0]  code;
    bit          fl;
    logic [29:0] w;
    logic [3:0]  c;
  } vec_t;
  vec_t vecs[6];

  typedef struct {
    logic [29:0] w;
    logic [3:0]  c;
  } word_t;
  word_t      expq[$];
  logic [1:0] cur[$];
  int         hs = 0;
  bit         prev_stall = 1'b0;
  logic [33:0] prev_out = '0;

  de2_115_web_qsys_cpu_oci_dct_packer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .code_in       (code_in),
    .code_valid    (code_valid),
    .code_ready    (code_ready),
    .flush         (flush),
    .dct_buffer    (dct_buffer),
    .dct_count     (dct_count),
    .dct_valid     (dct_valid),
    .dct_ready     (dct_ready),
    .idle          (idle),
    .words_emitted (words_emitted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input logic [1:0] c);
    for (int i = 0; i < n; i++) begin
      code_valid = 1'b1;
      code_in    = c;
      step();
    end
    code_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  // Reference: a word is the accepted codes in order, oldest most significant.
  task automatic close_word();
    logic [29:0] w;
    w = '0;
    foreach (cur[i]) w = (w << 2) | 30'(cur[i]);
    expq.push_back('{w, 4'(cur.size())});
    cur.delete();
  endtask

  task automatic sample();
    if (code_valid && code_ready) begin
      cur.push_back(code_in);
      if (cur.size() == 15) close_word();
    end
    if (prev_stall) check("hold_stable", {30'd0, dct_valid, dct_count, dct_buffer}, {30'd0, 1'b1, prev_out});
    if (dct_valid && dct_ready) begin
      hs++;
      if (expq.size() == 0) begin
        check("spurious_word", 64'(dct_valid), 64'd0);
      end else begin
        word_t e;
        e = expq.pop_front();
        check("rand_word", 64'(dct_buffer), 64'(e.w));
        check("rand_count", 64'(dct_count), 64'(e.c));
      end
    end
    prev_stall = dct_valid && !dct_ready;
    prev_out   = {dct_count, dct_buffer};
  endtask

  initial begin
    bit seen;
    int acc_n;

    vecs[0] = '{15, TAKEN,     1'b0, 30'h15555555, 4'd15};
    vecs[1] = '{15, NOT_TAKEN, 1'b0, 30'h2AAAAAAA, 4'd15};
    vecs[2] = '{15, ESCAPE,    1'b0, 30'h3FFFFFFF, 4'd15};
    vecs[3] = '{4,  ESCAPE,    1'b1, 30'h000000FF, 4'd4};
    vecs[4] = '{1,  TAKEN,     1'b1, 30'h00000001, 4'd1};
    vecs[5] = '{14, NOT_TAKEN, 1'b1, 30'h0AAAAAAA, 4'd14};

    // Reset state
    #2 reset_n = 1'b0;
    step();
    step();
    check("rst_valid", 64'(dct_valid), 64'd0);
    check("rst_buffer", 64'(dct_buffer), 64'd0);
    check("rst_count", 64'(dct_count), 64'd0);
    check("rst_words", 64'(words_emitted), 64'd0);
    check("rst_ready", 64'(code_ready), 64'd1);
    check("rst_idle", 64'(idle), 64'd1);
    reset_n = 1'b1;
    step();

    // Table: full words and flushed partial words, valid one cycle after the closing edge
    dct_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].n, vecs[i].code);
      if (vecs[i].fl) pulse_flush();
      check("vec_pre_valid", 64'(dct_valid), 64'd0);
      step();
      check("vec_valid", 64'(dct_valid), 64'd1);
      check("vec_buffer", 64'(dct_buffer), 64'(vecs[i].w));
      check("vec_count", 64'(dct_count), 64'(vecs[i].c));
      step();
      exp_we++;
      check("vec_drop", 64'(dct_valid), 64'd0);
      check("vec_words", 64'(words_emitted), 64'(exp_we));
      check("vec_idle", 64'(idle), 64'd1);
    end

    // Partial flush of 01,10,11
    code_valid = 1'b1;
    code_in = TAKEN;     step();
    code_in = NOT_TAKEN; step();
    code_in = ESCAPE;    step();
    code_valid = 1'b0;
    pulse_flush();
    step();
    check("pf_buffer", 64'(dct_buffer), 64'h1B);
    check("pf_count", 64'(dct_count), 64'd3);
    check("pf_idle_busy", 64'(idle), 64'd0);
    step();
    exp_we++;
    check("pf_idle", 64'(idle), 64'd1);

    // Empty flush emits nothing
    pulse_flush();
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      seen |= dct_valid;
      step();
    end
    check("ef_no_valid", 64'(seen), 64'd0);
    check("ef_words", 64'(words_emitted), 64'(exp_we));
    check("ef_idle", 64'(idle), 64'd1);

    // Backpressure: two words' worth of codes, then stall
    dct_ready = 1'b0;
    code_valid = 1'b1;
    code_in = NOT_TAKEN;
    acc_n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (code_ready) acc_n++;
      step();
    end
    @(negedge clk);
    check("bp_accepted", 64'(acc_n), 64'd30);
    check("bp_ready_low", 64'(code_ready), 64'd0);
    check("bp_valid", 64'(dct_valid), 64'd1);
    check("bp_buffer", 64'(dct_buffer), 64'h2AAAAAAA);
    code_valid = 1'b0;
    dct_ready = 1'b1;
    step();
    check("bp_second_valid", 64'(dct_valid), 64'd1);
    check("bp_second_buf", 64'(dct_buffer), 64'h2AAAAAAA);
    check("bp_second_cnt", 64'(dct_count), 64'd15);
    step();
    exp_we += 2;
    check("bp_drained", 64'(dct_valid), 64'd0);
    check("bp_words", 64'(words_emitted), 64'(exp_we));

    // Flush together with the 15th code: one full word, no empty follow-up
    send(14, ESCAPE);
    code_valid = 1'b1;
    code_in = ESCAPE;
    flush = 1'b1;
    step();
    code_valid = 1'b0;
    flush = 1'b0;
    check("fa_pre_valid", 64'(dct_valid), 64'd0);
    step();
    check("fa_count", 64'(dct_count), 64'd15);
    check("fa_buffer", 64'(dct_buffer), 64'h3FFFFFFF);
    step();
    exp_we++;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      seen |= dct_valid;
      step();
    end
    check("fa_no_extra", 64'(seen), 64'd0);
    check("fa_words", 64'(words_emitted), 64'(exp_we));

    // Asynchronous reset with a stalled word and 7 codes accumulated
    dct_ready = 1'b0;
    send(15, TAKEN);
    send(7, NOT_TAKEN);
    check("ar_held", 64'(dct_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("ar_valid", 64'(dct_valid), 64'd0);
    check("ar_buffer", 64'(dct_buffer), 64'd0);
    check("ar_count", 64'(dct_count), 64'd0);
    check("ar_words", 64'(words_emitted), 64'd0);
    check("ar_idle", 64'(idle), 64'd1);
    check("ar_code_ready", 64'(code_ready), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    dct_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      seen |= dct_valid;
    end
    check("ar_no_word", 64'(seen), 64'd0);
    check("ar_words_after", 64'(words_emitted), 64'd0);

    // Randomized traffic against the reference grouping model
    prev_stall = 1'b0;
    for (int k = 0; k < 800; k++) begin
      @(posedge clk);
      #1;
      code_valid = ($urandom_range(0, 9) < 7);
      code_in    = 2'($urandom);
      dct_ready  = ($urandom_range(0, 9) < 5);
      @(negedge clk);
      sample();
    end
    @(posedge clk);
    #1;
    code_valid = 1'b0;
    dct_ready  = 1'b1;
    flush      = 1'b1;
    @(negedge clk);
    sample();
    if (cur.size() > 0) close_word();
    @(posedge clk);
    #1;
    flush = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      sample();
      if (expq.size() == 0 && !dct_valid) break;
      @(posedge clk);
      #1;
    end
    check("rand_drained", 64'(expq.size()), 64'd0);
    check("rand_words_emitted", 64'(words_emitted), 64'(hs));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
